seven_seg_scroller: RTL



---
 rtl/seven_seg_scroller_pkg.sv | 27 ++
 rtl/seven_seg_scroller_tick_gen.sv | 33 +++
 rtl/seven_seg_scroller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seven_seg_scroller_pkg.sv
// Shared symbol codes, symbol width and scroller state encodings.
// Codes 0-F are hex digits; the SYM_* codes are also used by the decoder.
package seven_seg_scroller_pkg;

  localparam int unsigned SYM_W = 5;

  localparam logic [SYM_W-1:0] SYM_E     = 5'h0E;
  localparam logic [SYM_W-1:0] SYM_BLANK = 5'h10;
  localparam logic [SYM_W-1:0] SYM_DASH  = 5'h11;
  localparam logic [SYM_W-1:0] SYM_H     = 5'h12;
  localparam logic [SYM_W-1:0] SYM_L     = 5'h13;
  localparam logic [SYM_W-1:0] SYM_O     = 5'h14;
  localparam logic [SYM_W-1:0] SYM_P     = 5'h15;
  localparam logic [SYM_W-1:0] SYM_U     = 5'h16;

  typedef enum logic {
    SCROLL_IDLE = 1'b0,
    SCROLL_RUN  = 1'b1
  } scroll_state_e;

  // Dot is low-active: 0 = lit.
  typedef struct packed {
    logic             dot;
    logic [SYM_W-1:0] sym;
  } sym_entry_t;

endpackage

// File: rtl/seven_seg_scroller_tick_gen.sv
// Scroll-step prescaler: counts 0..TICK_DIV-1 while enabled, one-cycle tick_o on wrap.
module scroll_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == TW'(TICK_DIV - 1));
  assign tick_o = en_i && !restart_i && at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = at_top ? '0 : cnt_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seven_seg_scroller.sv
// Buffered message scroller feeding NUM_DIGITS seven-segment decoders.
// Optional SCROLL_ONESHOT_EN: stop after one pass and pulse done_o.
module seven_seg_scroller
  import seven_seg_scroller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        wr_valid_i,
  input  logic [SYM_W-1:0]            wr_sym_i,
  input  logic                        wr_dot_i,
  output logic                        wr_ready_o,
  input  logic                        clear_i,
  input  logic                        start_i,
  input  logic                        scroll_en_i,
  output logic [NUM_DIGITS*SYM_W-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]       dots_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned PW = $clog2(DEPTH + NUM_DIGITS);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  scroll_state_e                 state_q, state_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [PW-1:0]                 pos_q, pos_d;
  sym_entry_t                    buf_q [DEPTH];
  logic [NUM_DIGITS*SYM_W-1:0]   digits_q, digits_d;
  logic [NUM_DIGITS-1:0]         dots_q, dots_d;
  logic [PW:0]                   count_ext, period, idx;
  sym_entry_t                    entry;
  logic                          wr_fire, start_go, tick, wrap;

  assign wr_ready_o = (state_q == SCROLL_IDLE) && (count_q < CW'(DEPTH));
  assign wr_fire    = wr_valid_i && wr_ready_o && !clear_i;
  assign start_go   = !clear_i && start_i && (state_q == SCROLL_IDLE) && (count_q != '0);
  assign count_ext  = (PW+1)'(count_q);
  assign period     = count_ext + (PW+1)'(NUM_DIGITS);
  assign wrap       = tick && ({1'b0, pos_q} == period - (PW+1)'(1));
  assign busy_o     = (state_q == SCROLL_RUN);
  assign digits_o   = digits_q;
  assign dots_o     = dots_q;

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .en_i      ((state_q == SCROLL_RUN) && scroll_en_i),
    .restart_i (start_go || clear_i),
    .tick_o    (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pos_d   = pos_q;
    if (clear_i) begin
      state_d = SCROLL_IDLE;
      count_d = '0;
      pos_d   = '0;
    end else begin
      if (wr_fire) count_d = count_q + CW'(1);
      if (start_go) begin
        state_d = SCROLL_RUN;
        pos_d   = '0;
      end else if (state_q == SCROLL_RUN && tick) begin
        if (wrap) begin
          pos_d = '0;
`ifdef SCROLL_ONESHOT_EN
          state_d = SCROLL_IDLE;
`endif
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end
    end
  end

  // Window index wraps with one conditional subtract: pos < PERIOD and k < NUM_DIGITS <= PERIOD.
  always_comb begin
    digits_d = {NUM_DIGITS{SYM_BLANK}};
    dots_d   = '1;
    idx      = '0;
    entry    = '0;
    if (state_q == SCROLL_RUN && !clear_i) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        idx = {1'b0, pos_q} + (PW+1)'(k);
        if (idx >= period) idx = idx - period;
        if (idx < count_ext) begin
          entry = buf_q[idx[AW-1:0]];
          digits_d[SYM_W*(NUM_DIGITS-1-k) +: SYM_W] = entry.sym;
          dots_d[NUM_DIGITS-1-k]                    = entry.dot;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= SCROLL_IDLE;
      count_q  <= '0;
      pos_q    <= '0;
      digits_q <= {NUM_DIGITS{SYM_BLANK}};
      dots_q   <= '1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pos_q    <= pos_d;
      digits_q <= digits_d;
      dots_q   <= dots_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) buf_q[count_q[AW-1:0]] <= '{dot: wr_dot_i, sym: wr_sym_i};
  end

`ifdef SCROLL_ONESHOT_EN
  logic done_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) done_q <= 1'b0;
    else          done_q <= !clear_i && (state_q == SCROLL_RUN) && wrap;
  end

  assign done_o = done_q;
`else
  assign done_o = 1'b0;
`endif

endmodule
